// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: zero-latency hazard/ready -> enables path; stall counter and bus_error update one clock later.
// Backpressure: no advance while PIPELINE_READY is low; a data-memory miss parks in MEMWAIT until mem_ready or the watchdog fires.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             if_ready,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             s_loaduse,
  input  logic             s_branch_jr_ok,
  input  logic             md_busy,
  input  logic             id_s_md_use,
  input  logic             exc_req,
  output logic             PIPELINE_READY,
  output logic             if_en,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             id_bubble,
  output logic             flush_all,
  output logic             pc_redirect,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEMWAIT  = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  localparam logic [15:0]      TIMEOUT_V = 16'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_nxt;
  logic        bus_error_set;
  logic        ready;
  logic        hazard;
  logic        stall_cycle;

  assign ready  = if_ready & (~mem_req | mem_ready);
  assign hazard = s_loaduse | ~s_branch_jr_ok | (id_s_md_use & md_busy);

  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    bus_error_set  = 1'b0;
    PIPELINE_READY = 1'b0;
    if_en          = 1'b0;
    id_en          = 1'b0;
    ex_en          = 1'b0;
    mem_en         = 1'b0;
    wb_en          = 1'b0;
    id_bubble      = 1'b0;
    flush_all      = 1'b0;
    pc_redirect    = 1'b0;

    case (state)
      ST_RUN: begin
        PIPELINE_READY = ready;
        if (ready) begin
          ex_en  = 1'b1;
          mem_en = 1'b1;
          wb_en  = 1'b1;
          if (exc_req) begin
            // Exception beats any hazard: the whole front end is flushed anyway.
            if_en     = 1'b1;
            id_en     = 1'b1;
            flush_all = 1'b1;
            state_nxt = ST_REDIRECT;
          end else if (hazard) begin
            id_bubble = 1'b1;
          end else begin
            if_en = 1'b1;
            id_en = 1'b1;
          end
        end else if (mem_req && !mem_ready) begin
          state_nxt    = ST_MEMWAIT;
          wait_cnt_nxt = 16'd1;
        end
      end

      ST_MEMWAIT: begin
        if (mem_ready) begin
          state_nxt = ST_RUN;
        end else if (wait_cnt == TIMEOUT_V) begin
          bus_error_set = 1'b1;
          flush_all     = 1'b1;
          state_nxt     = ST_REDIRECT;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end

      ST_REDIRECT: begin
        pc_redirect = 1'b1;
        state_nxt   = ST_RUN;
      end

      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign stall_cycle = ~PIPELINE_READY | id_bubble;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      wait_cnt  <= 16'd0;
      bus_error <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (bus_error_set) begin
        bus_error <= 1'b1;
      end
      if (stall_cycle && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
    end
  end

endmodule
